// File: rtl/pic_regfile_pkg.sv
// Shared constants and helpers for the banked PIC16C5x register file:
// file addresses, writeCommand encodings, STATUS bit positions, reset values
// and the effective-address to GPR-index mapping.
package pic_regfile_pkg;

    // Low five bits of the effective address
    localparam logic [4:0] ADDR_INDF            = 5'h00;
    localparam logic [4:0] ADDR_TMR0            = 5'h01;
    localparam logic [4:0] ADDR_PCL             = 5'h02;
    localparam logic [4:0] ADDR_STATUS          = 5'h03;
    localparam logic [4:0] ADDR_FSR             = 5'h04;
    localparam logic [4:0] ADDR_PORTA           = 5'h05;
    localparam logic [4:0] ADDR_PORTB           = 5'h06;
    localparam logic [4:0] ADDR_PORTC           = 5'h07;
    localparam logic [4:0] ADDR_GPR_COMMON_BASE = 5'h08;
    localparam logic [4:0] ADDR_GPR_BANK_BASE   = 5'h10;

    // writeCommand encodings (110/111 behave as NONE)
    localparam logic [2:0] WCMD_NONE        = 3'b000;
    localparam logic [2:0] WCMD_STATUS      = 3'b001;
    localparam logic [2:0] WCMD_FILE        = 3'b010;
    localparam logic [2:0] WCMD_FILE_STATUS = 3'b011;
    localparam logic [2:0] WCMD_FSR         = 3'b100;
    localparam logic [2:0] WCMD_TRIS        = 3'b101;

    // STATUS bit indices
    localparam int STATUS_C   = 0;
    localparam int STATUS_DC  = 1;
    localparam int STATUS_Z   = 2;
    localparam int STATUS_PD  = 3;
    localparam int STATUS_TO  = 4;
    localparam int STATUS_PA0 = 5;
    localparam int STATUS_PA2 = 7;

    // Reset values
    localparam logic [7:0] STATUS_RST = 8'h18;
    localparam logic [7:0] PORT_RST   = 8'h00;
    localparam logic [7:0] TMR0_RST   = 8'h00;
    localparam logic [7:0] GPR_RST    = 8'h00;

    // Number of FSR bank-select bits for a given bank count
    function automatic int bank_bits(input int num_banks);
        return (num_banks >= 4) ? 2 : (num_banks == 2) ? 1 : 0;
    endfunction

    // FSR bits above the implemented address range are stuck at 1
    function automatic logic [7:0] fsr_fixed(input int bw);
        return 8'hFF << (5 + bw);
    endfunction

    // Effective address (bank bits in [6:5]) to flat GPR index.
    // Only valid for low addresses 0x08..0x1F; common words occupy 0..7,
    // bank b occupies 8+16*b .. 8+16*b+15.
    function automatic logic [6:0] gpr_index(input logic [6:0] ea);
        if (ea[4:0] < ADDR_GPR_BANK_BASE)
            return {2'b00, ea[4:0]} - 7'd8;
        else
            return {1'b0, ea[6:5], ea[3:0]} + 7'd8;
    endfunction

endpackage

// File: rtl/pic_tmr0.sv
// Free-running 8-bit TMR0 counter. A load replaces the count and holds it
// for the two following edges before counting resumes.
module pic_tmr0 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count
);

    logic [1:0] inhibit;

    // Count every edge unless a recent load is still holding the value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            inhibit <= 2'd0;
        end else if (load) begin
            count   <= load_data;
            inhibit <= 2'd2;
        end else if (inhibit != 2'd0) begin
            inhibit <= inhibit - 2'd1;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pic_regfile_banked.sv
// Banked PIC16C5x register file: SFRs, common + banked GPR, FSR indirect
// addressing, port latches with TRIS direction registers.
// Optional TMR0 counter enabled by defining REGFILE_TMR0_EN; otherwise
// address 0x01 reads 0 and ignores writes.
module pic_regfile_banked
    import pic_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 11,
    parameter int NUM_BANKS  = 4,
    parameter int IO_A_WIDTH = 4,
    parameter int IO_B_WIDTH = 8,
    parameter int IO_C_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            writeCommand,
    input  logic [4:0]            fileAddr,
    input  logic [DATA_WIDTH-1:0] writeDataIn,
    input  logic [DATA_WIDTH-1:0] statusIn,
    input  logic [PC_WIDTH-1:0]   pcIn,
    input  logic [IO_A_WIDTH-1:0] portAIn,
    input  logic [IO_B_WIDTH-1:0] portBIn,
    input  logic [IO_C_WIDTH-1:0] portCIn,
    output logic [DATA_WIDTH-1:0] regfileOut,
    output logic [DATA_WIDTH-1:0] fsrOut,
    output logic [DATA_WIDTH-1:0] statusOut,
    output logic [IO_A_WIDTH-1:0] portAOut,
    output logic [IO_B_WIDTH-1:0] portBOut,
    output logic [IO_C_WIDTH-1:0] portCOut,
    output logic [IO_A_WIDTH-1:0] trisAOut,
    output logic [IO_B_WIDTH-1:0] trisBOut,
    output logic [IO_C_WIDTH-1:0] trisCOut
);

    localparam int             BW        = bank_bits(NUM_BANKS);
    localparam int             GPR_WORDS = 8 + 16 * NUM_BANKS;
    localparam int             IDXW      = $clog2(GPR_WORDS);
    localparam logic [7:0]     FSR_FIX   = fsr_fixed(BW);
    localparam logic [6:0]     EA_MASK   = 7'((32 * NUM_BANKS) - 1);

    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] fsr;
    logic [DATA_WIDTH-1:0] gpr [GPR_WORDS];
    logic [IO_A_WIDTH-1:0] lat_a, tris_a;
    logic [IO_B_WIDTH-1:0] lat_b, tris_b;
    logic [IO_C_WIDTH-1:0] lat_c, tris_c;
    logic [DATA_WIDTH-1:0] tmr_val;

    logic [6:0]            ea;
    logic [4:0]            ea_lo;
    logic [6:0]            gidx;
    logic                  file_we;
    logic                  status_ld;
    logic [DATA_WIDTH-1:0] status_src;
    logic [IO_A_WIDTH-1:0] rd_a;
    logic [IO_B_WIDTH-1:0] rd_b;
    logic [IO_C_WIDTH-1:0] rd_c;

    // PCL only exposes the low byte of the program counter
    logic unused_pc;
    assign unused_pc = ^pcIn;

    // Effective address: INDF goes through FSR, anything else is banked
    // by the FSR bank bits. Masking drops bits beyond the implemented range.
    assign ea      = (fileAddr == ADDR_INDF) ? (fsr[6:0] & EA_MASK)
                                             : ({fsr[6:5], fileAddr} & EA_MASK);
    assign ea_lo   = ea[4:0];
    assign gidx    = gpr_index(ea);

    assign file_we    = (writeCommand == WCMD_FILE) || (writeCommand == WCMD_FILE_STATUS);
    assign status_ld  = (writeCommand == WCMD_STATUS) || (writeCommand == WCMD_FILE_STATUS);
    // TO/PD never come from file data: new ALU status if present, else kept
    assign status_src = status_ld ? statusIn : status;

    // Pins for input bits, latch for output bits
    assign rd_a = (tris_a & portAIn) | (~tris_a & lat_a);
    assign rd_b = (tris_b & portBIn) | (~tris_b & lat_b);
    assign rd_c = (tris_c & portCIn) | (~tris_c & lat_c);

`ifdef REGFILE_TMR0_EN
    logic tmr_load;
    assign tmr_load = file_we && (ea_lo == ADDR_TMR0);

    pic_tmr0 #(.WIDTH(DATA_WIDTH)) u_tmr0 (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_data (writeDataIn),
        .count     (tmr_val)
    );
`else
    assign tmr_val = TMR0_RST;
`endif

    // Combinational read of the addressed file from current state
    always_comb begin
        regfileOut = '0;
        case (ea_lo)
            ADDR_INDF:   regfileOut = '0;
            ADDR_TMR0:   regfileOut = tmr_val;
            ADDR_PCL:    regfileOut = pcIn[7:0];
            ADDR_STATUS: regfileOut = status;
            ADDR_FSR:    regfileOut = fsr;
            ADDR_PORTA:  regfileOut = DATA_WIDTH'(rd_a);
            ADDR_PORTB:  regfileOut = DATA_WIDTH'(rd_b);
            ADDR_PORTC:  regfileOut = DATA_WIDTH'(rd_c);
            default:     regfileOut = gpr[gidx[IDXW-1:0]];
        endcase
    end

    // STATUS: file writes keep TO/PD from status_src; otherwise ALU load
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            status <= STATUS_RST;
        else if (file_we && (ea_lo == ADDR_STATUS))
            status <= {writeDataIn[STATUS_PA2:STATUS_PA0],
                       status_src[STATUS_TO:STATUS_PD],
                       writeDataIn[STATUS_Z:STATUS_C]};
        else if (status_ld)
            status <= statusIn;
    end

    // FSR: direct file write or dedicated command; unimplemented bits stay 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fsr <= FSR_FIX;
        else if ((writeCommand == WCMD_FSR) || (file_we && (ea_lo == ADDR_FSR)))
            fsr <= writeDataIn | FSR_FIX;
    end

    // Port output latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_a <= PORT_RST[IO_A_WIDTH-1:0];
            lat_b <= PORT_RST[IO_B_WIDTH-1:0];
            lat_c <= PORT_RST[IO_C_WIDTH-1:0];
        end else if (file_we) begin
            if (ea_lo == ADDR_PORTA) lat_a <= writeDataIn[IO_A_WIDTH-1:0];
            if (ea_lo == ADDR_PORTB) lat_b <= writeDataIn[IO_B_WIDTH-1:0];
            if (ea_lo == ADDR_PORTC) lat_c <= writeDataIn[IO_C_WIDTH-1:0];
        end
    end

    // TRIS registers, selected by the low three address bits of a TRIS command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tris_a <= '1;
            tris_b <= '1;
            tris_c <= '1;
        end else if (writeCommand == WCMD_TRIS) begin
            if (fileAddr[2:0] == ADDR_PORTA[2:0]) tris_a <= writeDataIn[IO_A_WIDTH-1:0];
            if (fileAddr[2:0] == ADDR_PORTB[2:0]) tris_b <= writeDataIn[IO_B_WIDTH-1:0];
            if (fileAddr[2:0] == ADDR_PORTC[2:0]) tris_c <= writeDataIn[IO_C_WIDTH-1:0];
        end
    end

    // General-purpose RAM: common and banked words in one flat array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GPR_WORDS; i++) gpr[i] <= GPR_RST;
        end else if (file_we && (ea_lo >= ADDR_GPR_COMMON_BASE)) begin
            gpr[gidx[IDXW-1:0]] <= writeDataIn;
        end
    end

    assign fsrOut    = fsr;
    assign statusOut = status;
    assign portAOut  = lat_a;
    assign portBOut  = lat_b;
    assign portCOut  = lat_c;
    assign trisAOut  = tris_a;
    assign trisBOut  = tris_b;
    assign trisCOut  = tris_c;

endmodule

// File: tb/tb_pic_regfile_banked.sv
// Scoreboard bench for pic_regfile_banked (4 banks). The driver pushes the
// expected outputs from a behavioural model; a negedge monitor pops and compares.
module tb_pic_regfile_banked;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] writeCommand;
    logic [4:0] fileAddr;
    logic [7:0] writeDataIn, statusIn;
    logic [10:0] pcIn;
    logic [3:0] portAIn;
    logic [7:0] portBIn, portCIn;
    logic [7:0] regfileOut, fsrOut, statusOut;
    logic [3:0] portAOut, trisAOut;
    logic [7:0] portBOut, portCOut, trisBOut, trisCOut;

    pic_regfile_banked #(.NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst), .writeCommand(writeCommand), .fileAddr(fileAddr),
        .writeDataIn(writeDataIn), .statusIn(statusIn), .pcIn(pcIn),
        .portAIn(portAIn), .portBIn(portBIn), .portCIn(portCIn),
        .regfileOut(regfileOut), .fsrOut(fsrOut), .statusOut(statusOut),
        .portAOut(portAOut), .portBOut(portBOut), .portCOut(portCOut),
        .trisAOut(trisAOut), .trisBOut(trisBOut), .trisCOut(trisCOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd, fsr, st, pa, pb, pc, ta, tb, tc, lit;
        string name;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    // ---------------- behavioural model ----------------
    int m_mem[128];
    int m_st, m_fsr, m_tmr, m_hold;
    int m_lat[3], m_tris[3];
    int pin[3];
    int pcv;
    int wmask[3] = '{'h0F, 'hFF, 'hFF};
    int fixed_bits = 'h80;          // FSR bits above the 7-bit address range

    function automatic void model_reset();
        m_st = 'h18; m_fsr = fixed_bits; m_tmr = 0; m_hold = 0;
        for (int i = 0; i < 3; i++) begin m_lat[i] = 0; m_tris[i] = wmask[i]; end
        for (int i = 0; i < 128; i++) m_mem[i] = 0;
    endfunction

    // Full address in the 32*NB-word space
    function automatic int ea_of(int a);
        int lim = 32 * NB - 1;
        if (a == 0) return m_fsr & lim;
        return (m_fsr & lim & ~31) | a;
    endfunction

    // Canonical location: 0x00-0x0F are shared by all banks
    function automatic int canon(int ea);
        return ((ea & 31) < 16) ? (ea & 31) : ea;
    endfunction

    function automatic int m_read(int a);
        int ea = ea_of(a);
        int lo = ea & 31;
        case (lo)
            0: return 0;
            1: return m_tmr;
            2: return pcv & 'hFF;
            3: return m_st;
            4: return m_fsr;
            5, 6, 7: return ((m_tris[lo-5] & pin[lo-5]) | (~m_tris[lo-5] & m_lat[lo-5])) & wmask[lo-5];
            default: return m_mem[canon(ea)];
        endcase
    endfunction

    function automatic void model_edge(int cmd, int a, int wd, int si);
        int ea = ea_of(a);
        int lo = ea & 31;
        bit fw = (cmd == 2 || cmd == 3);
        int n_st = m_st;
        int n_fsr = m_fsr;
        bit tload = 0;
        if (cmd == 1 || cmd == 3) n_st = si;
        if (fw) begin
            if (lo == 1) tload = 1;
            else if (lo == 3) n_st = (wd & 'hE7) | (((cmd == 3) ? si : m_st) & 'h18);
            else if (lo == 4) n_fsr = (wd | fixed_bits) & 'hFF;
            else if (lo >= 5 && lo <= 7) m_lat[lo-5] = wd & wmask[lo-5];
            else if (lo >= 8) m_mem[canon(ea)] = wd;
        end
        if (cmd == 4) n_fsr = (wd | fixed_bits) & 'hFF;
        if (cmd == 5 && (a & 7) >= 5) m_tris[(a & 7) - 5] = wd & wmask[(a & 7) - 5];
`ifdef REGFILE_TMR0_EN
        if (tload) begin m_tmr = wd; m_hold = 2; end
        else if (m_hold > 0) m_hold--;
        else m_tmr = (m_tmr + 1) & 'hFF;
`else
        if (tload) m_tmr = 0;
`endif
        m_st = n_st;
        m_fsr = n_fsr;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input int cmd, input int a, input int wd, input int si,
                        input int lit = -1, input string nm = "plan");
        exp_t e;
        pcv = int'($urandom_range(0, 2047));
        writeCommand = 3'(cmd); fileAddr = 5'(a); writeDataIn = 8'(wd);
        statusIn = 8'(si); pcIn = 11'(pcv);
        portAIn = 4'(pin[0]); portBIn = 8'(pin[1]); portCIn = 8'(pin[2]);
        e.rd = m_read(a); e.fsr = m_fsr; e.st = m_st;
        e.pa = m_lat[0]; e.pb = m_lat[1]; e.pc = m_lat[2];
        e.ta = m_tris[0]; e.tb = m_tris[1]; e.tc = m_tris[2];
        e.lit = lit; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(cmd, a, wd, si);
        #1;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("regfileOut", int'(regfileOut), e.rd);
            chk("fsrOut", int'(fsrOut), e.fsr);
            chk("statusOut", int'(statusOut), e.st);
            chk("portAOut", int'(portAOut), e.pa);
            chk("portBOut", int'(portBOut), e.pb);
            chk("portCOut", int'(portCOut), e.pc);
            chk("trisAOut", int'(trisAOut), e.ta);
            chk("trisBOut", int'(trisBOut), e.tb);
            chk("trisCOut", int'(trisCOut), e.tc);
            if (e.lit >= 0) chk(e.name, int'(regfileOut), e.lit);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        writeCommand = 3'd0; fileAddr = 5'd0; writeDataIn = 8'd0; statusIn = 8'd0;
        pcIn = 11'd0; pin[0] = 'h9; pin[1] = 'h5C; pin[2] = 'hC3;
        portAIn = 4'h9; portBIn = 8'h5C; portCIn = 8'hC3;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        step(0, 'h03, 0, 0, 'h18, "rst_status");
        step(0, 'h04, 0, 0, 'h80, "rst_fsr");
        step(0, 'h05, 0, 0, 'h9, "rst_porta_pins");

        // banked GPR
        step(4, 0, 'h20, 0);
        step(2, 'h10, 'h55, 0);
        step(4, 0, 'h40, 0);
        step(2, 'h10, 'hAA, 0);
        step(4, 0, 'h20, 0);
        step(0, 'h10, 0, 0, 'h55, "bank1_0x10");
        step(4, 0, 'h40, 0);
        step(0, 'h10, 0, 0, 'hAA, "bank2_0x10");

        // common GPR aliasing
        step(2, 'h08, 'h5A, 0);
        for (int b = 0; b < NB; b++) begin
            step(4, 0, b << 5, 0);
            step(0, 'h08, 0, 0, 'h5A, "common_0x08");
        end

        // indirect access
        step(4, 0, 'h4A, 0);
        step(2, 0, 'h33, 0);
        step(0, 'h0A, 0, 0, 'h33, "indf_write");
        step(4, 0, 'h00, 0);
        step(0, 0, 0, 0, 0, "indf_self_read");

        // TRIS / port mixing
        step(5, 6, 'h0F, 0);
        step(2, 6, 'hA5, 0);
        pin[1] = 'h3C;
        step(0, 6, 0, 0, 'hAC, "portb_mix");

        // STATUS write with ALU status
        step(3, 3, 'hFF, 'h00);
        step(0, 3, 0, 0, 'hE7, "status_011");

        // TMR0
`ifdef REGFILE_TMR0_EN
        step(2, 1, 'hFE, 0);
        step(0, 1, 0, 0, 'hFE, "tmr0_n");
        step(0, 1, 0, 0, 'hFE, "tmr0_n1");
        step(0, 1, 0, 0, 'hFE, "tmr0_n2");
        step(0, 1, 0, 0, 'hFF, "tmr0_n3");
        step(0, 1, 0, 0, 'h00, "tmr0_n4");
`else
        step(2, 1, 'hFE, 0);
        step(0, 1, 0, 0, 0, "tmr0_absent");
`endif

        // mid-operation reset, write during reset ignored
        step(2, 'h15, 'h77, 0);
        rst = 1'b1;
        #1;
        model_reset();
        step(2, 'h15, 'h66, 0, 'h00, "rst_gpr");
        rst = 1'b0;
        step(0, 'h04, 0, 0, 'h80, "rst_mid_fsr");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int cmd, a;
            pin[0] = int'($urandom_range(0, 15));
            pin[1] = int'($urandom_range(0, 255));
            pin[2] = int'($urandom_range(0, 255));
            cmd = int'($urandom_range(0, 7));
            a = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a = int'($urandom_range(8, 31));
            step(cmd, a, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_regfile_banked.md
# pic_regfile_banked

Parametrised, banked successor to the PIC16C5x core register file: special-function registers, banked general-purpose RAM, FSR-based indirect addressing, per-port TRIS direction registers and an optional free-running TMR0. Sits between the ALU/decoder (`writeCommand`, `fileAddr`, `writeDataIn`, `statusIn`) and the I/O pads. It covers the 16C54-style single-bank and 16C57-style four-bank devices from one source.

## Interface
- `DATA_WIDTH`, 8: register width; must be 8.
- `PC_WIDTH`, 11: program counter width; PCL reads `pcIn[7:0]`.
- `NUM_BANKS`, 4: GPR banks; legal values 1, 2, 4.
- `IO_A_WIDTH` / `IO_B_WIDTH` / `IO_C_WIDTH`, 4 / 8 / 8: port widths.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `writeCommand`  in  3  000 none, 001 status only, 010 file write, 011 file write plus status, 100 FSR write, 101 TRIS write, 110/111 none.
- `fileAddr`  in  5  direct file address.
- `writeDataIn`  in  8  write data.
- `statusIn`  in  8  ALU status.
- `pcIn`  in  `PC_WIDTH`  current PC.
- `portAIn` / `portBIn` / `portCIn`  in  port width  pad inputs.
- `regfileOut`  out  8  combinational read of the addressed file.
- `fsrOut`, `statusOut`  out  8  register contents.
- `portAOut` / `portBOut` / `portCOut`  out  port width  output latches.
- `trisAOut` / `trisBOut` / `trisCOut`  out  port width  direction (1 = input).

## Operation
- Bank select: `BW = log2(NUM_BANKS)`, which is 0 for one bank. Direct effective address = `{FSR[4+BW:5], fileAddr}`. Indirect effective address (`fileAddr`=0x00) = `FSR[4+BW:0]`.
- Address map, low 5 bits:
  - 0x00 INDF: read 0, write ignored.
  - 0x01 TMR0.
  - 0x02 PCL: read only.
  - 0x03 STATUS.
  - 0x04 FSR.
  - 0x05–0x07 PORTA–PORTC.
  - 0x08–0x0F common GPR: 8 words, shared by all banks.
  - 0x10–0x1F banked GPR: 16×`NUM_BANKS` words.
- Addresses 0x00–0x0F alias in every bank.
- FSR: bits above `4+BW` always read 1 and ignore writes.
- Port reads: `(tris & pin) | (~tris & latch)`, zero-extended to 8 bits.
- STATUS:
  - File writes update bits 7:5 and 2:0 only; bits 4:3 (TO, PD) change only through `statusIn`.
  - Command 011 targeting STATUS: result = `{writeDataIn[7:5], statusIn[4:3], writeDataIn[2:0]}`.
- Command 100 writes FSR regardless of `fileAddr` (masked as above).
- Command 101: `fileAddr[2:0]` of 5/6/7 loads TRISA/B/C from `writeDataIn`; any other address is a no-op.
- Reset values:
  - STATUS 0x18.
  - FSR = all unimplemented bits 1, rest 0 (0xE0 for 1 bank, 0x80 for 4 banks).
  - Port latches 0.
  - TRIS all 1.
  - TMR0 0.
  - All GPR 0.
  - `regfileOut` follows the reset state combinationally.

## Timing
- Reads are combinational from current state, zero latency. A write at edge N is visible from N+ onward; a same-cycle read returns the old value.
- A write to FSR changes indirect and banked targets from the next cycle.
- TMR0 increments by 1 every cycle and wraps 0xFF→0x00. A file write to TMR0 at edge N loads the data, and increments are suppressed at edges N+1 and N+2.
- Reset asserted mid-operation: all state returns to reset values immediately. The first write is accepted at the first rising edge after deassertion.

## Configuration
- `REGFILE_TMR0_EN` defined: TMR0 counter and write-inhibit implemented as above.
- Undefined: 0x01 reads 0 and writes are ignored; no counter flops.

## Structure
- Package `pic_regfile_pkg`: `ADDR_*` constants (INDF..PORTC, GPR_COMMON_BASE, GPR_BANK_BASE), `writeCommand` encodings (`WCMD_*`), STATUS bit indices, reset constants.
- Sub-module `pic_tmr0`: 8-bit counter with load and 2-cycle inhibit, instantiated under `REGFILE_TMR0_EN`.
- GPR is a flat array of 8 + 16×`NUM_BANKS` words with a package function that maps effective address to index.

## Test plan
- Reset, then read 0x03/0x04/0x05 → 0x18 / 0x80 (`NUM_BANKS`=4) / pin value with TRIS=0xF.
- FSR=0x20, write 0x55 to 0x10; FSR=0x40, write 0xAA to 0x10 → reading 0x10 with FSR=0x20 gives 0x55, with FSR=0x40 gives 0xAA. Address 0x08 returns the same word in all banks.
- FSR=0x4A, write 0x33 via INDF → direct read of 0x0A gives 0x33. FSR=0x00, INDF read → 0.
- TRIS 101 to addr 6 with 0x0F, latch B=0xA5, pins=0x3C → `regfileOut`=0xAC.
- Command 011, addr 0x03, data 0xFF, statusIn=0x00 → STATUS=0xE7.
- TMR0 write 0xFE at edge N → reads 0xFE at N+1 and N+2, 0xFF at N+3, 0x00 at N+4.
